// File: rtl/day002.sv
// Purpose    : 1:2 valid/ready stream demux with one registered output slot per
//              channel and a wrapping delivered-transfer counter per channel.
// Latency    : 1 cycle from input acceptance to x_valid_o; full throughput per channel.
// Backpressure: ready_o follows only the selected slot, so a stalled channel
//              never blocks words routed to the other channel.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   din_i, sel_i        - input payload, route select (1 = A, 0 = B)
//   valid_i, ready_o    - input handshake (ready_o combinational, 0 in reset)
//   a_o, a_valid_o      - channel A payload/valid (registered)
//   a_ready_i           - channel A downstream ready
//   b_o, b_valid_o      - channel B payload/valid (registered)
//   b_ready_i           - channel B downstream ready
//   a_cnt_o, b_cnt_o    - per-channel transfer counts, modulo 2^CNT_W
module day002 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din_i,
  input  logic             sel_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] a_o,
  output logic             a_valid_o,
  input  logic             a_ready_i,
  output logic [WIDTH-1:0] b_o,
  output logic             b_valid_o,
  input  logic             b_ready_i,
  output logic [CNT_W-1:0] a_cnt_o,
  output logic [CNT_W-1:0] b_cnt_o
);

  logic a_free;
  logic b_free;
  logic accept;
  logic load_a;
  logic load_b;
  logic xfer_a;
  logic xfer_b;

  // A slot can take a new word if it is empty or being drained this edge.
  assign a_free  = !a_valid_o || a_ready_i;
  assign b_free  = !b_valid_o || b_ready_i;
  assign ready_o = !reset && (sel_i ? a_free : b_free);

  assign accept  = valid_i && ready_o;
  assign load_a  = accept && sel_i;
  assign load_b  = accept && !sel_i;
  assign xfer_a  = a_valid_o && a_ready_i;
  assign xfer_b  = b_valid_o && b_ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_o       <= '0;
      a_valid_o <= 1'b0;
      b_o       <= '0;
      b_valid_o <= 1'b0;
      a_cnt_o   <= '0;
      b_cnt_o   <= '0;
    end else begin
      // Reload wins over drain so a same-edge transfer+load stays FULL.
      if (load_a) begin
        a_o       <= din_i;
        a_valid_o <= 1'b1;
      end else if (xfer_a) begin
        a_valid_o <= 1'b0;
      end

      if (load_b) begin
        b_o       <= din_i;
        b_valid_o <= 1'b1;
      end else if (xfer_b) begin
        b_valid_o <= 1'b0;
      end

      if (xfer_a) a_cnt_o <= a_cnt_o + 1'b1;
      if (xfer_b) b_cnt_o <= b_cnt_o + 1'b1;
    end
  end

endmodule

// File: doc/day002.md
DAY002 -- requirements
Module: day002

Interface
REQ-001 Parameter: WIDTH, default 8, data width of input and both output channels.
REQ-002 Parameter: CNT_W, default 8, width of each per-channel delivered-transfer counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  reset; synchronous and active-high.
REQ-005 din_i  input  WIDTH  input payload.
REQ-006 sel_i  input  1  route select; 1 routes to channel A, 0 routes to channel B; same polarity as the day001 mux.
REQ-007 valid_i  input  1  input payload valid.
REQ-008 ready_o  output  1  input ready; combinational.
REQ-009 a_o  output  WIDTH  channel A payload, registered.
REQ-010 a_valid_o  output  1  channel A valid, registered.
REQ-011 a_ready_i  input  1  channel A downstream ready.
REQ-012 b_o  output  WIDTH  channel B payload, registered.
REQ-013 b_valid_o  output  1  channel B valid, registered.
REQ-014 b_ready_i  input  1  channel B downstream ready.
REQ-015 a_cnt_o  output  CNT_W  count of transfers completed on channel A, registered.
REQ-016 b_cnt_o  output  CNT_W  count of transfers completed on channel B, registered.

Function
REQ-017 The block SHALL be a 1:2 valid/ready stream demultiplexer with one output register slot per channel; each slot is EMPTY (x_valid_o=0) or FULL (x_valid_o=1).
REQ-018 Input acceptance SHALL occur on an edge where valid_i=1 and ready_o=1.
REQ-019 ready_o SHALL equal (!a_valid_o || a_ready_i) when sel_i=1, (!b_valid_o || b_ready_i) when sel_i=0, and SHALL be 0 while reset=1.
REQ-020 On acceptance the selected slot SHALL load din_i and set its valid; latency from acceptance edge to x_valid_o=1 is exactly 1 cycle.
REQ-021 A channel transfer SHALL occur on an edge where x_valid_o=1 and x_ready_i=1; the slot SHALL go EMPTY unless reloaded on the same edge.
REQ-022 Simultaneous transfer and reload of the same slot SHALL keep x_valid_o=1 and replace the payload (full throughput, one word per cycle per channel).
REQ-023 A FULL slot with x_ready_i=0 SHALL hold payload and valid unchanged; the unselected slot SHALL never change except by its own transfer.
REQ-024 x_o SHALL hold its last value after the slot goes EMPTY (no clearing on drain).
REQ-025 A stall on one channel SHALL NOT block acceptance routed to the other channel.
REQ-026 valid_i=0 SHALL cause no slot load regardless of sel_i or din_i.
REQ-027 a_cnt_o/b_cnt_o SHALL increment by 1 on each transfer of their channel, modulo 2^CNT_W (all-ones wraps to 0, no saturation or flag).
REQ-028 Payload SHALL pass bit-exact; no reordering within a channel.

Reset
REQ-029 With reset=1 on an edge: a_valid_o=0, b_valid_o=0, a_o=0, b_o=0, a_cnt_o=0, b_cnt_o=0.
REQ-030 Reset mid-operation SHALL discard any FULL slot payload with no transfer counted; reset SHALL take priority over simultaneous acceptance and transfer.
REQ-031 The first acceptance SHALL be possible on the first edge with reset=0.

Verification
REQ-032 Reset, then din_i=8'hAA, sel_i=1, valid_i=1 one cycle, a_ready_i=1 -> next cycle a_o=8'hAA, a_valid_o=1; after transfer a_cnt_o=1, b_valid_o=0.
REQ-033 b_ready_i=0, send 8'h55 with sel_i=0 -> b_valid_o=1 held; second sel_i=0 word sees ready_o=0; concurrent sel_i=1 word 8'h11 accepted and appears on a_o.
REQ-034 Back-to-back 8'h00,8'h01,8'h02 to A with a_ready_i=1 every cycle -> ready_o=1 throughout, a_o shows each word one cycle after acceptance, a_cnt_o=3.
REQ-035 CNT_W=8, 256 transfers on B -> b_cnt_o wraps to 0; 257th -> b_cnt_o=1.
REQ-036 Slot A FULL with 8'hFF, assert reset one cycle -> a_valid_o=0, a_o=0, a_cnt_o=0, ready_o=0 during reset.
REQ-037 Random sel_i/valid_i/ready stimulus, 1000 cycles -> scoreboard per channel matches order and data, counters equal scoreboard transfer counts.
